// File: rtl/axi_lite_sram_responder_pkg.sv
// axi_lite_sram_responder_pkg: shared response codes, FSM states and address decode for the SRAM responder
package axi_lite_sram_responder_pkg;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int CNT_W = 8;
    typedef enum logic [2:0] {IDLE, R_WAIT, R_RESP, W_COLLECT, W_WAIT, B_RESP} state_t;
    // 34-bit compare so DEPTH*4 cannot wrap for the full 32-bit address space
    function automatic logic in_range(input logic [31:0] addr, input logic [31:0] base, input int depth);
        logic [31:0] off;
        off = addr - base;
        return {2'b00, off} < ({2'b00, 32'(depth)} << 2);
    endfunction
endpackage

// File: rtl/axi_lite_sram_array.sv
// axi_lite_sram_array: word-addressed storage with combinational read and byte-enabled synchronous write
module axi_lite_sram_array
    import axi_lite_sram_responder_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];
    always_ff @(posedge clock)
        if (we)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    assign rdata = mem[raddr];
endmodule

// File: rtl/axi_lite_sram_responder.sv
// axi_lite_sram_responder: single-outstanding AXI4-Lite slave over an SRAM with fixed read/write latency
module axi_lite_sram_responder
    import axi_lite_sram_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int DEPTH = 1024,
    parameter int RD_LATENCY = 2,
    parameter int WR_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    input  logic        bready,
    output logic [1:0]  bresp,
    output logic        bvalid
);
    localparam int AW = $clog2(DEPTH);
    state_t state;
    logic [CNT_W-1:0] cnt;
    logic [31:0] ar_addr, aw_addr, w_data, mem_rdata;
    logic [3:0] w_strb;
    logic aw_got, w_got, aw_hs, w_hs, ar_ok, aw_ok, we;
    logic [AW-1:0] ar_idx, aw_idx;
    assign ar_ok = in_range(ar_addr, BASE_ADDR, DEPTH);
    assign aw_ok = in_range(aw_addr, BASE_ADDR, DEPTH);
    assign ar_idx = AW'((ar_addr - BASE_ADDR) >> 2);
    assign aw_idx = AW'((aw_addr - BASE_ADDR) >> 2);
    // arready doubles as the registered "idle and out of reset" flag, so reset forces every ready low
    assign awready = state == IDLE ? arready && !arvalid : state == W_COLLECT && !aw_got;
    assign wready = state == IDLE ? arready && !arvalid : state == W_COLLECT && !w_got;
    assign aw_hs = awvalid && awready;
    assign w_hs = wvalid && wready;
    assign we = !reset && state == W_WAIT && cnt == '0 && aw_ok;
    axi_lite_sram_array #(.DEPTH(DEPTH)) u_array (
        .clock(clock),
        .we(we),
        .be(w_strb),
        .waddr(aw_idx),
        .wdata(w_data),
        .raddr(ar_idx),
        .rdata(mem_rdata)
    );
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            ar_addr <= '0;
            aw_addr <= '0;
            w_data <= '0;
            w_strb <= '0;
            aw_got <= 1'b0;
            w_got <= 1'b0;
            arready <= 1'b0;
            rvalid <= 1'b0;
            rdata <= '0;
            rresp <= RESP_OKAY;
            bvalid <= 1'b0;
            bresp <= RESP_OKAY;
        end else begin
            case (state)
                IDLE: begin
                    if (arvalid && arready) begin
                        ar_addr <= araddr;
                        cnt <= CNT_W'(RD_LATENCY);
                        arready <= 1'b0;
                        state <= R_WAIT;
                    end else if (aw_hs || w_hs) begin
                        if (aw_hs) aw_addr <= awaddr;
                        if (w_hs) begin
                            w_data <= wdata;
                            w_strb <= wstrb;
                        end
                        aw_got <= aw_hs;
                        w_got <= w_hs;
                        cnt <= CNT_W'(WR_LATENCY);
                        arready <= 1'b0;
                        state <= aw_hs && w_hs ? W_WAIT : W_COLLECT;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (cnt == '0) begin
                        rdata <= ar_ok ? mem_rdata : '0;
                        rresp <= ar_ok ? RESP_OKAY : RESP_SLVERR;
                        rvalid <= 1'b1;
                        state <= R_RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        rvalid <= 1'b0;
                        rdata <= '0;
                        rresp <= RESP_OKAY;
                        arready <= 1'b1;
                        state <= IDLE;
                    end
                end
                W_COLLECT: begin
                    if (aw_hs) begin
                        aw_addr <= awaddr;
                        aw_got <= 1'b1;
                    end
                    if (w_hs) begin
                        w_data <= wdata;
                        w_strb <= wstrb;
                        w_got <= 1'b1;
                    end
                    if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                        cnt <= CNT_W'(WR_LATENCY);
                        state <= W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (cnt == '0) begin
                        bresp <= aw_ok ? RESP_OKAY : RESP_SLVERR;
                        bvalid <= 1'b1;
                        state <= B_RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                B_RESP: begin
                    if (bready) begin
                        bvalid <= 1'b0;
                        bresp <= RESP_OKAY;
                        aw_got <= 1'b0;
                        w_got <= 1'b0;
                        arready <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_sram_responder.sv
// tb_axi_lite_sram_responder: randomized AXI4-Lite traffic against an array-based memory model
module tb_axi_lite_sram_responder;
    import axi_lite_sram_responder_pkg::*;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int DEPTH = 1024;
    localparam int RDL = 2;
    localparam int WRL = 2;
    logic clock, reset;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic arvalid, arready, rready, rvalid, awvalid, awready, wvalid, wready, bready, bvalid;
    logic [3:0] wstrb;
    logic [1:0] rresp, bresp;
    logic [40:0] outs;
    logic [31:0] model [DEPTH];
    int n_checks = 0;
    int n_fail = 0;
    assign outs = {arready, awready, wready, rvalid, bvalid, rdata, rresp, bresp};
    axi_lite_sram_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .RD_LATENCY(RDL), .WR_LATENCY(WRL)) dut (
        .clock(clock), .reset(reset),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rready(rready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bready(bready), .bresp(bresp), .bvalid(bvalid)
    );
    initial clock = 1'b0;
    always #5 clock = ~clock;
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end
    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask
    function automatic logic exp_ok(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off < 32'(DEPTH * 4);
    endfunction
    function automatic logic [31:0] exp_rdata(input logic [31:0] a);
        return exp_ok(a) ? model[int'((a - BASE) / 4)] : 32'h0;
    endfunction
    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (exp_ok(a))
            for (int i = 0; i < 4; i++)
                if (s[i]) model[int'((a - BASE) / 4)][8*i +: 8] = d[8*i +: 8];
    endfunction
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int gap, input int bwait);
        int t_aw, t_w, t, lat;
        bit aw_done, w_done, aw_h, w_h;
        logic [1:0] er;
        er = exp_ok(a) ? RESP_OKAY : RESP_SLVERR;
        t_aw = gap > 0 ? gap : 0;
        t_w = gap < 0 ? -gap : 0;
        aw_done = 0;
        w_done = 0;
        t = 0;
        while (!(aw_done && w_done) && t < 100) begin
            @(negedge clock);
            if (t == t_aw) begin awvalid = 1; awaddr = a; end
            if (t == t_w) begin wvalid = 1; wdata = d; wstrb = s; end
            #1;
            if (w_done && !aw_done && !awvalid) begin
                check("wready_low_after_w", wready, 0);
                check("awready_waiting", awready, 1);
            end
            if (aw_done && !w_done && !wvalid) begin
                check("awready_low_after_aw", awready, 0);
                check("wready_waiting", wready, 1);
            end
            aw_h = awvalid && awready;
            w_h = wvalid && wready;
            @(posedge clock);
            #1;
            if (aw_h) begin awvalid = 0; aw_done = 1; end
            if (w_h) begin wvalid = 0; w_done = 1; end
            t++;
        end
        check("write_handshake", aw_done && w_done, 1);
        model_write(a, d, s);
        lat = 0;
        while (!bvalid && lat < 300) begin @(posedge clock); #1; lat++; end
        check("write_latency", lat, WRL + 1);
        check("bresp", bresp, er);
        repeat (bwait) begin @(posedge clock); #1; check("b_held", {bvalid, bresp}, {1'b1, er}); end
        bready = 1;
        @(posedge clock);
        #1;
        bready = 0;
        check("b_cleared", {bvalid, bresp, arready}, 4'b0001);
    endtask
    task automatic axi_read(input logic [31:0] a, input int rwait, output logic [31:0] d);
        int t, lat;
        logic [31:0] ed;
        logic [1:0] er;
        ed = exp_rdata(a);
        er = exp_ok(a) ? RESP_OKAY : RESP_SLVERR;
        @(negedge clock);
        arvalid = 1;
        araddr = a;
        #1;
        t = 0;
        while (!arready && t < 100) begin @(negedge clock); #1; t++; end
        check("ar_accepted", arready, 1);
        @(posedge clock);
        #1;
        arvalid = 0;
        lat = 0;
        while (!rvalid && lat < 300) begin @(posedge clock); #1; lat++; end
        check("read_latency", lat, RDL + 1);
        d = rdata;
        check("rdata", rdata, ed);
        check("rresp", rresp, er);
        repeat (rwait) begin @(posedge clock); #1; check("r_held", {rvalid, rresp, rdata}, {1'b1, er, ed}); end
        rready = 1;
        @(posedge clock);
        #1;
        rready = 0;
        check("r_cleared", {rvalid, rdata, arready}, {1'b0, 32'h0, 1'b1});
    endtask
    initial begin
        logic [31:0] d, a, old;
        int t;
        bit seen;
        reset = 1;
        {arvalid, rready, awvalid, wvalid, bready} = '0;
        araddr = '0; awaddr = '0; wdata = '0; wstrb = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", outs, 0);
        @(negedge clock);
        reset = 0;
        @(posedge clock);
        #1;
        check("idle_readies", {arready, awready, wready}, 3'b111);
        for (int w = 0; w < 16; w++) axi_write(BASE + 32'(w * 4), $urandom, 4'hF, 0, 0);
        axi_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0);
        axi_read(BASE + 32'h10, 0, d);
        check("basic_readback", d, 32'hDEAD_BEEF);
        axi_write(BASE + 32'h10, 32'h1122_3344, 4'hF, 0, 0);
        axi_write(BASE + 32'h10, 32'hAABB_CCDD, 4'b0101, 0, 0);
        axi_read(BASE + 32'h10, 0, d);
        check("byte_strobe_merge", d, 32'h11BB_33DD);
        axi_write(BASE + 32'h20, 32'h1234_5678, 4'hF, 4, 0);
        seen = 0;
        repeat (4) begin @(posedge clock); #1; seen |= bvalid; end
        check("single_b_pulse", seen, 0);
        axi_read(BASE + 32'h20, 0, d);
        check("w_first_readback", d, 32'h1234_5678);
        @(negedge clock);
        arvalid = 1; araddr = BASE + 32'h10;
        awvalid = 1; awaddr = BASE + 32'h24; wvalid = 1; wdata = 32'h5A5A_0F0F; wstrb = 4'hF;
        #1;
        check("sim_readies", {arready, awready, wready}, 3'b100);
        old = exp_rdata(BASE + 32'h10);
        @(posedge clock);
        #1;
        arvalid = 0;
        seen = 0;
        t = 0;
        while (!rvalid && t < 50) begin seen |= awready | wready; @(posedge clock); #1; t++; end
        check("sim_read_first", {rvalid, rdata, seen}, {1'b1, old, 1'b0});
        rready = 1;
        @(posedge clock);
        #1;
        rready = 0;
        check("sim_write_after_r", {awready, wready}, 2'b11);
        @(posedge clock);
        #1;
        awvalid = 0; wvalid = 0;
        model_write(BASE + 32'h24, 32'h5A5A_0F0F, 4'hF);
        t = 0;
        while (!bvalid && t < 50) begin @(posedge clock); #1; t++; end
        check("sim_write_latency", t, WRL + 1);
        bready = 1;
        @(posedge clock);
        #1;
        bready = 0;
        axi_read(BASE + 32'h24, 0, d);
        axi_read(32'h7FFF_FFFC, 0, d);
        axi_read(BASE + 32'h1000, 1, d);
        old = exp_rdata(BASE);
        axi_write(BASE + 32'h1000, 32'hFFFF_FFFF, 4'hF, 0, 1);
        axi_read(BASE, 0, d);
        check("oor_write_no_alias", d, old);
        axi_read(BASE + 32'h10, 5, d);
        @(negedge clock);
        arvalid = 1; araddr = BASE + 32'h10;
        @(posedge clock);
        #1;
        arvalid = 0;
        #2;
        reset = 1;
        #1;
        check("reset_in_r_wait", outs, 0);
        @(posedge clock);
        @(negedge clock);
        reset = 0;
        seen = 0;
        repeat (8) begin @(posedge clock); #1; seen |= rvalid; end
        check("no_r_after_reset", seen, 0);
        axi_read(BASE + 32'h10, 0, d);
        @(negedge clock);
        arvalid = 1; araddr = BASE + 32'h10;
        @(posedge clock);
        #1;
        arvalid = 0;
        t = 0;
        while (!rvalid && t < 50) begin @(posedge clock); #1; t++; end
        check("r_resp_before_reset", rdata, exp_rdata(BASE + 32'h10));
        #2;
        reset = 1;
        #1;
        check("async_reset_in_r_resp", outs, 0);
        @(negedge clock);
        reset = 0;
        @(negedge clock);
        awvalid = 1; awaddr = BASE + 32'h14; wvalid = 1; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
        @(posedge clock);
        #1;
        awvalid = 0; wvalid = 0;
        #2;
        reset = 1;
        #1;
        check("reset_in_w_wait", outs, 0);
        @(posedge clock);
        @(negedge clock);
        reset = 0;
        seen = 0;
        repeat (6) begin @(posedge clock); #1; seen |= bvalid; end
        check("no_b_after_reset", seen, 0);
        axi_read(BASE + 32'h14, 0, d);
        for (int i = 0; i < 60; i++) begin
            a = BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = $urandom_range(0, 1) ? BASE - 32'd4 : BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 255) * 4);
            if ($urandom_range(0, 1))
                axi_write(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 3)));
            else
                axi_read(a, int'($urandom_range(0, 3)), d);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_lite_sram_responder.md
Name: axi_lite_sram_responder

Overview:
- AXI4-Lite responder (slave end): the initiator-side arbiter's downstream channels (ar/r/aw/w/b) terminate here.
- Backs a word-addressed SRAM with byte-strobe writes and fixed, parameterised read and write latency.
- Used as the simulation memory behind the arbiter and to exercise its handshakes.
- Single outstanding transaction; simultaneous read and write requests are resolved read-first.

Parameters:
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- DEPTH, 1024, number of 32-bit words (power of two).
- RD_LATENCY, 2, wait cycles between AR handshake and first rvalid cycle (0..255).
- WR_LATENCY, 2, wait cycles between last of AW/W handshake and first bvalid cycle (0..255).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; fixed as decided.
- araddr  in  32  read address.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rready  in  1  read data ready.
- rdata  out  32  read data.
- rresp  out  2  read response.
- rvalid  out  1  read data valid.
- awaddr  in  32  write address.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wdata  in  32  write data.
- wstrb  in  4  byte strobes; bit i selects wdata[8i+7:8i].
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bready  in  1  write response ready.
- bresp  out  2  write response.
- bvalid  out  1  write response valid.

Behaviour:
- Reset values: state=IDLE; latency counter=0; all capture registers and flags=0; every output=0 (arready, awready, wready, rvalid, bvalid, rdata, rresp, bresp). SRAM contents are not reset.
- Reset mid-transaction: abandon immediately; no partial SRAM write; no response is issued after reset deasserts.
- State IDLE:
  - arready=1; awready=!arvalid; wready=!arvalid.
  - arvalid wins over awvalid/wvalid in the same cycle.
  - AR handshake: latch araddr; counter=RD_LATENCY; go to R_WAIT.
  - AW and/or W handshake: latch addr and/or data+strb; set aw_got/w_got; go to W_COLLECT. If both arrive in the same cycle, go directly to W_WAIT.
- State R_WAIT:
  - All readies 0.
  - Counter decrements each cycle; at 0, load rdata/rresp and go to R_RESP.
  - RD_LATENCY=0: rvalid rises in the cycle after the AR handshake.
- State R_RESP:
  - rvalid=1; rdata/rresp held stable until rready.
  - On rvalid&&rready: rvalid=0 next cycle; return to IDLE, where arready=1 that next cycle.
- State W_COLLECT:
  - awready=!aw_got; wready=!w_got; arvalid is ignored.
  - When both captured: counter=WR_LATENCY; go to W_WAIT.
- State W_WAIT:
  - Counts down like R_WAIT.
  - At 0: perform the SRAM write for each set strobe bit (only if address is in range); go to B_RESP.
- State B_RESP:
  - bvalid=1; bresp held stable until bready; then return to IDLE.
- Address decode:
  - offset = addr − BASE_ADDR, 32-bit unsigned wrap.
  - In range iff offset < DEPTH*4; word index = offset[log2(DEPTH)+1:2]; addr[1:0] ignored.
  - Out of range: resp=2'b10 (SLVERR), rdata=0, no write.
  - In range: resp=2'b00 (OKAY).
- A read issued after a write's bvalid observes the written data. wstrb=0 is accepted with OKAY and writes nothing.
- rdata is 0 whenever rvalid=0.

Decomposition:
- Shared package:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - State enum {IDLE, R_WAIT, R_RESP, W_COLLECT, W_WAIT, B_RESP}, 3 bits.
  - Latency counter width 8.
- Sub-module axi_lite_sram_array:
  - DEPTH×32 storage with combinational read by word index.
  - Synchronous write with 4-bit byte enable and write-enable.
  - No reset.

Test Plan:
- Basic write/read, RD_LATENCY=2: write 0x8000_0010 data 0xDEADBEEF wstrb 4'hF, aw and w same cycle, bready=1 → bvalid exactly 3 cycles after handshake, bresp=0. Then read same address → rvalid 3 cycles after AR handshake, rdata=0xDEADBEEF, rresp=0.
- Byte strobes: word holds 0x11223344; write 0xAABBCCDD wstrb 4'b0101 → read returns 0x11BB33DD.
- W before AW, 4 cycles apart: wready drops after W handshake while awready stays 1 until AW. A single write occurs; one bvalid pulse.
- Simultaneous arvalid and awvalid in IDLE:
  - Read accepted first; awready=0 that cycle.
  - Write is accepted only after rvalid&&rready.
- Out of range: read 0x7FFF_FFFC and 0x8000_1000 → rresp=2'b10, rdata=0. Write 0x8000_1000 → bresp=2'b10, SRAM unchanged (verified by readback of word 0).
- Backpressure and reset: hold rready=0 for 5 cycles → rvalid and rdata stable. Assert reset while in R_WAIT → all outputs 0 asynchronously; no rvalid after release; next read behaves normally.
